// File: rtl/axil_master_bridge.sv
// axil_master_bridge
// Turns the CPU native memory port (valid/ready, wstrb-encoded direction) into a
// single outstanding AXI4-Lite master transaction. A saturating bus timer forces
// completion with an error if a slave never answers, so the CPU cannot hang.

module axil_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // CPU native memory port
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,
    // AXI4-Lite write address channel
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    // AXI4-Lite write data channel
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    // AXI4-Lite write response channel
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    // AXI4-Lite read address channel
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    // AXI4-Lite read data channel
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WRESP   = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    // Counter is one bit wider than strictly needed so it also has room when the
    // timeout is disabled (TIMEOUT = 0); it saturates instead of wrapping.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t                state_r, state_nxt;
    logic                  awvalid_r, awvalid_nxt;
    logic                  wvalid_r, wvalid_nxt;
    logic                  bready_r, bready_nxt;
    logic                  arvalid_r, arvalid_nxt;
    logic                  rready_r, rready_nxt;
    logic                  ready_r, ready_nxt;
    logic                  err_r, err_nxt;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt;
    logic [CW-1:0]         cnt_r, cnt_nxt;
    logic                  latch_s;
    logic                  timeout_s;

    // Request copy taken at acceptance; drives the AXI payload so it stays stable
    // while the CPU side is free to change.
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;
    logic                  instr_r;

    // Only the error bit of each response matters; OKAY and EXOKAY are both success.
    logic                  resp_unused_s;
    assign resp_unused_s = m_axil_bresp[0] ^ m_axil_rresp[0];

    // Next-state and next-output logic for the transaction FSM and bus timer.
    always_comb begin
        state_nxt   = state_r;
        awvalid_nxt = awvalid_r;
        wvalid_nxt  = wvalid_r;
        bready_nxt  = bready_r;
        arvalid_nxt = arvalid_r;
        rready_nxt  = rready_r;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;
        rdata_nxt   = rdata_r;
        cnt_nxt     = cnt_r;
        latch_s     = 1'b0;
        timeout_s   = 1'b0;

        if (state_r != IDLE) begin
            cnt_nxt   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
            timeout_s = TO_EN && (cnt_r == TO_LIMIT);
        end else begin
            timeout_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                // The cycle mem_ready is high the CPU still shows the old request.
                if (mem_valid && !ready_r) begin
                    latch_s = 1'b1;
                    cnt_nxt = {CW{1'b0}};
                    if (mem_wstrb != {STRB_WIDTH{1'b0}}) begin
                        state_nxt   = WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD_ADDR;
                        arvalid_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                // AW and W complete independently, in any order.
                awvalid_nxt = awvalid_r && !m_axil_awready;
                wvalid_nxt  = wvalid_r && !m_axil_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WRESP;
                    bready_nxt = 1'b1;
                end else begin
                    state_nxt = WR;
                end
            end
            WRESP: begin
                if (m_axil_bvalid && bready_r) begin
                    bready_nxt = 1'b0;
                    ready_nxt  = 1'b1;
                    err_nxt    = m_axil_bresp[1];
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = WRESP;
                end
            end
            RD_ADDR: begin
                // rready only after AR: some slaves hold rvalid high permanently.
                if (m_axil_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_DATA;
                end else begin
                    state_nxt = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid && rready_r) begin
                    rready_nxt = 1'b0;
                    rdata_nxt  = m_axil_rdata;
                    err_nxt    = m_axil_rresp[1];
                    ready_nxt  = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = RD_DATA;
                end
            end
            default: begin
                state_nxt   = IDLE;
                awvalid_nxt = 1'b0;
                wvalid_nxt  = 1'b0;
                bready_nxt  = 1'b0;
                arvalid_nxt = 1'b0;
                rready_nxt  = 1'b0;
            end
        endcase

        // Dead-slave recovery: abandon the bus transfer and complete with an error.
        if (timeout_s) begin
            awvalid_nxt = 1'b0;
            wvalid_nxt  = 1'b0;
            bready_nxt  = 1'b0;
            arvalid_nxt = 1'b0;
            rready_nxt  = 1'b0;
            ready_nxt   = 1'b1;
            err_nxt     = 1'b1;
            state_nxt   = IDLE;
            if ((state_r == RD_ADDR) || (state_r == RD_DATA)) begin
                rdata_nxt = TIMEOUT_DATA;
            end else begin
                rdata_nxt = rdata_r;
            end
        end else begin
            cnt_nxt = cnt_nxt;
        end
    end

    // State, registered outputs, timer and latched request.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r   <= IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_WIDTH{1'b0}};
            instr_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            awvalid_r <= awvalid_nxt;
            wvalid_r  <= wvalid_nxt;
            bready_r  <= bready_nxt;
            arvalid_r <= arvalid_nxt;
            rready_r  <= rready_nxt;
            ready_r   <= ready_nxt;
            err_r     <= err_nxt;
            rdata_r   <= rdata_nxt;
            cnt_r     <= cnt_nxt;
            if (latch_s) begin
                addr_r  <= mem_addr;
                wdata_r <= mem_wdata;
                wstrb_r <= mem_wstrb;
                instr_r <= mem_instr;
            end
        end
    end

    assign mem_ready      = ready_r;
    assign mem_err        = err_r;
    assign mem_rdata      = rdata_r;

    assign m_axil_awaddr  = addr_r;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_r;
    assign m_axil_wdata   = wdata_r;
    assign m_axil_wstrb   = wstrb_r;
    assign m_axil_wvalid  = wvalid_r;
    assign m_axil_bready  = bready_r;
    assign m_axil_araddr  = addr_r;
    assign m_axil_arprot  = {instr_r, 2'b00};
    assign m_axil_arvalid = arvalid_r;
    assign m_axil_rready  = rready_r;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed testbench for axil_master_bridge. The slave side is scripted cycle by
// cycle from the test tasks; inputs change and outputs are sampled on negedge.

module tb_axil_master_bridge;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        mem_valid, mem_instr, mem_ready, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    // Values captured by the zero-wait helpers, compared by the calling test.
    logic        o_v1, o_rdy1, o_hs2, o_rdy2, o_rdy3, o_err3, o_rdy4, o_dup4;
    logic [31:0] o_addr1, o_data3, o_wdata1;
    logic [2:0]  o_prot1;
    logic [3:0]  o_strb1;

    axil_master_bridge #(.TIMEOUT(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Zero-wait read: request in cycle N, mem_ready expected in cycle N+3.
    task automatic zw_read(input logic [31:0] addr, input logic instr,
                           input logic [31:0] data, input logic [1:0] resp);
        @(negedge aclk);
        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr;
        mem_wstrb = 4'b0000; mem_wdata = 32'h0000_0000;
        arready = 1'b1; rvalid = 1'b0;
        @(negedge aclk);
        o_v1 = arvalid; o_addr1 = araddr; o_prot1 = arprot; o_rdy1 = mem_ready;
        rvalid = 1'b1; rdata = data; rresp = resp;
        @(negedge aclk);
        o_hs2 = rready & ~arvalid; o_rdy2 = mem_ready;
        @(negedge aclk);
        o_rdy3 = mem_ready; o_data3 = mem_rdata; o_err3 = mem_err;
        rvalid = 1'b0; arready = 1'b0;
        @(negedge aclk);
        o_rdy4 = mem_ready; o_dup4 = arvalid | awvalid; mem_valid = 1'b0;
    endtask

    // Zero-wait write: AW and W accepted together, B one cycle later.
    task automatic zw_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        @(negedge aclk);
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = addr;
        mem_wdata = data; mem_wstrb = strb;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        @(negedge aclk);
        o_v1 = awvalid & wvalid; o_addr1 = awaddr; o_wdata1 = wdata; o_strb1 = wstrb;
        o_prot1 = awprot; o_rdy1 = mem_ready;
        bvalid = 1'b1; bresp = resp;
        @(negedge aclk);
        o_hs2 = bready & ~awvalid & ~wvalid; o_rdy2 = mem_ready;
        @(negedge aclk);
        o_rdy3 = mem_ready; o_data3 = mem_rdata; o_err3 = mem_err;
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge aclk);
        o_rdy4 = mem_ready; o_dup4 = arvalid | awvalid; mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_wstrb = 4'h0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if ({mem_ready, mem_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mem: got %b expected 00", {mem_ready, mem_err});
        end
        checks++;
        if (mem_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", mem_rdata);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_read();
        zw_read(32'h0000_0010, 1'b0, 32'h1234_5678, 2'b00);
        checks++;
        if ({o_v1, o_addr1, o_prot1} !== {1'b1, 32'h0000_0010, 3'b000}) begin
            errors++;
            $display("FAIL read_ar: got v=%b addr=%h prot=%b expected v=1 addr=00000010 prot=000", o_v1, o_addr1, o_prot1);
        end
        checks++;
        if ({o_rdy1, o_hs2, o_rdy2, o_rdy3, o_rdy4} !== 5'b01010) begin
            errors++;
            $display("FAIL read_latency: got %b expected 01010", {o_rdy1, o_hs2, o_rdy2, o_rdy3, o_rdy4});
        end
        checks++;
        if ({o_data3, o_err3} !== {32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL read_data: got %h err=%b expected 12345678 err=0", o_data3, o_err3);
        end
        checks++;
        if (o_dup4 !== 1'b0) begin
            errors++;
            $display("FAIL read_no_dup: got %b expected 0", o_dup4);
        end
    endtask

    // awready arrives two cycles after wready; CPU inputs change mid-transaction.
    task automatic test_write();
        logic [5:0] rdy_seen;
        @(negedge aclk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hAABB_CCDD;
        mem_wstrb = 4'b0110; wready = 1'b1; awready = 1'b0; bvalid = 1'b0;
        @(negedge aclk); // N+1
        rdy_seen[0] = mem_ready;
        checks++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb, awprot} !== {1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0110, 3'b000}) begin
            errors++;
            $display("FAIL write_launch: got aw=%b w=%b addr=%h data=%h strb=%b prot=%b", awvalid, wvalid, awaddr, wdata, wstrb, awprot);
        end
        mem_addr = 32'h0000_0999; mem_wdata = 32'h0; mem_wstrb = 4'hF;
        @(negedge aclk); // N+2
        rdy_seen[1] = mem_ready;
        checks++;
        if ({awvalid, wvalid} !== 2'b10) begin
            errors++;
            $display("FAIL write_w_first: got aw/w=%b expected 10", {awvalid, wvalid});
        end
        wready = 1'b0;
        @(negedge aclk); // N+3
        rdy_seen[2] = mem_ready;
        checks++;
        if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h0000_0020}) begin
            errors++;
            $display("FAIL write_aw_hold: got aw/w/b=%b addr=%h expected 100 addr=00000020", {awvalid, wvalid, bready}, awaddr);
        end
        awready = 1'b1;
        @(negedge aclk); // N+4
        rdy_seen[3] = mem_ready;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++;
            $display("FAIL write_bready: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        end
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge aclk); // N+5
        rdy_seen[4] = mem_ready;
        checks++;
        if ({mem_err, bready} !== 2'b00) begin
            errors++;
            $display("FAIL write_done: got err/bready=%b expected 00", {mem_err, bready});
        end
        bvalid = 1'b0;
        @(negedge aclk); // N+6
        rdy_seen[5] = mem_ready;
        mem_valid = 1'b0;
        checks++;
        if (rdy_seen !== 6'b010000) begin
            errors++;
            $display("FAIL write_single_ready: got %b expected 010000", rdy_seen);
        end
        checks++;
        if ({awvalid, arvalid} !== 2'b00) begin
            errors++;
            $display("FAIL write_no_dup: got aw/ar=%b expected 00", {awvalid, arvalid});
        end
    endtask

    // Slave keeps rvalid high all the time; only post-AR data may be returned.
    task automatic test_stale_rvalid();
        logic [1:0] early_rready;
        @(negedge aclk);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b00; arready = 1'b0;
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0044; mem_wstrb = 4'b0000;
        @(negedge aclk); // N+1
        early_rready[0] = rready;
        checks++;
        if ({arvalid, arprot, araddr} !== {1'b1, 3'b100, 32'h0000_0044}) begin
            errors++;
            $display("FAIL stale_ar: got v=%b prot=%b addr=%h expected v=1 prot=100 addr=00000044", arvalid, arprot, araddr);
        end
        @(negedge aclk); // N+2
        early_rready[1] = rready;
        checks++;
        if ({early_rready, mem_ready} !== 3'b000) begin
            errors++;
            $display("FAIL stale_rready_early: got rready=%b ready=%b expected 00/0", early_rready, mem_ready);
        end
        arready = 1'b1; rdata = 32'hCAFE_F00D;
        @(negedge aclk); // N+3
        checks++;
        if ({arvalid, rready, mem_ready} !== 3'b010) begin
            errors++;
            $display("FAIL stale_after_ar: got ar/r/ready=%b expected 010", {arvalid, rready, mem_ready});
        end
        arready = 1'b0;
        @(negedge aclk); // N+4
        checks++;
        if ({mem_ready, mem_rdata, mem_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            errors++;
            $display("FAIL stale_data: got ready=%b data=%h err=%b expected 1 cafef00d 0", mem_ready, mem_rdata, mem_err);
        end
        rvalid = 1'b0;
        @(negedge aclk);
        mem_valid = 1'b0; mem_instr = 1'b0;
    endtask

    task automatic test_errors();
        zw_read(32'h0000_0100, 1'b0, 32'h0BAD_F00D, 2'b10);
        checks++;
        if ({o_rdy3, o_err3, o_data3} !== {1'b1, 1'b1, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL err_slverr_read: got ready=%b err=%b data=%h expected 1 1 0badf00d", o_rdy3, o_err3, o_data3);
        end
        zw_write(32'h0000_0104, 32'h1111_2222, 4'b1111, 2'b11);
        checks++;
        if ({o_rdy1, o_hs2, o_rdy2, o_rdy3, o_err3} !== 5'b01011) begin
            errors++;
            $display("FAIL err_decerr_write: got %b expected 01011", {o_rdy1, o_hs2, o_rdy2, o_rdy3, o_err3});
        end
        checks++;
        if (o_data3 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL err_write_keeps_rdata: got %h expected 0badf00d", o_data3);
        end
    endtask

    task automatic test_back_to_back();
        zw_write(32'h0000_0200, 32'h0102_0304, 4'b0001, 2'b00);
        checks++;
        if ({o_v1, o_addr1, o_wdata1, o_strb1, o_rdy3, o_err3, o_dup4} !== {1'b1, 32'h0000_0200, 32'h0102_0304, 4'b0001, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_write: got v=%b addr=%h data=%h strb=%b ready=%b err=%b dup=%b", o_v1, o_addr1, o_wdata1, o_strb1, o_rdy3, o_err3, o_dup4);
        end
        zw_read(32'h0000_0203, 1'b1, 32'h5A5A_A5A5, 2'b01);
        checks++;
        if ({o_addr1, o_prot1, o_rdy3, o_data3, o_err3} !== {32'h0000_0203, 3'b100, 1'b1, 32'h5A5A_A5A5, 1'b0}) begin
            errors++;
            $display("FAIL b2b_fetch: got addr=%h prot=%b ready=%b data=%h err=%b", o_addr1, o_prot1, o_rdy3, o_data3, o_err3);
        end
    endtask

    // TIMEOUT=16: mem_ready rises 16 edges after the accepting edge, i.e. it is
    // first seen at the 17th negedge after the request is driven.
    task automatic test_timeout();
        int lat;
        logic held, t_err, t_ar, t_r;
        logic [31:0] t_data;
        lat = 0; held = 1'b1; t_err = 1'b0; t_ar = 1'b1; t_r = 1'b1; t_data = 32'h0;
        @(negedge aclk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0080; mem_wstrb = 4'b0000;
        arready = 1'b0; rvalid = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge aclk);
            if (mem_ready) begin
                lat = i; t_err = mem_err; t_data = mem_rdata; t_ar = arvalid; t_r = rready;
            end else if (!arvalid) begin
                held = 1'b0;
            end
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 17", lat);
        end
        checks++;
        if ({t_err, t_data, t_ar, t_r, held} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_result: got err=%b data=%h ar=%b r=%b held=%b expected 1 deadbeef 0 0 1", t_err, t_data, t_ar, t_r, held);
        end
        @(negedge aclk);
        mem_valid = 1'b0;
        checks++;
        if ({mem_ready, arvalid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got ready/ar=%b expected 00", {mem_ready, arvalid});
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] post;
        @(negedge aclk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h7777_8888;
        mem_wstrb = 4'b1100; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_launch: got aw/w=%b expected 11", {awvalid, wvalid});
        end
        aresetn = 1'b0; mem_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_rdata} !== {6'b000000, 32'h0}) begin
            errors++;
            $display("FAIL midrst_clear: got %b rdata=%h expected 000000 rdata=00000000", {awvalid, wvalid, bready, arvalid, rready, mem_ready}, mem_rdata);
        end
        aresetn = 1'b1;
        @(negedge aclk); post[0] = mem_ready | awvalid;
        @(negedge aclk); post[1] = mem_ready | awvalid;
        checks++;
        if (post !== 2'b00) begin
            errors++;
            $display("FAIL midrst_no_ready: got %b expected 00", post);
        end
        zw_read(32'h0000_0030, 1'b0, 32'h55AA_55AA, 2'b00);
        checks++;
        if ({o_rdy2, o_rdy3, o_data3, o_err3} !== {1'b0, 1'b1, 32'h55AA_55AA, 1'b0}) begin
            errors++;
            $display("FAIL midrst_recover: got ready2=%b ready3=%b data=%h err=%b", o_rdy2, o_rdy3, o_data3, o_err3);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stale_rvalid();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
